// File: rtl/exu_pipe.sv
// Two-stage execute pipeline: stage 1 resolves bypasses and selects ALU operands,
// stage 2 computes the ALU result (including RV64 W-ops) behind valid/ready handshakes.
module exu_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_BYPASS = 2,
  parameter int WORD_OPS   = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic                             ers1_i,
  input  logic                             ers2_i,
  input  logic [2:0]                       specinst_i,
  input  logic [3:0]                       alu_op_i,
  input  logic                             word_op_i,
  input  logic [4:0]                       rs1_idx_i,
  input  logic [4:0]                       rs2_idx_i,
  input  logic [DATA_WIDTH-1:0]            rs1_i,
  input  logic [DATA_WIDTH-1:0]            rs2_i,
  input  logic [DATA_WIDTH-1:0]            pc_i,
  input  logic [DATA_WIDTH-1:0]            imme_i,
  input  logic [NUM_BYPASS-1:0]            byp_valid_i,
  input  logic [5*NUM_BYPASS-1:0]          byp_idx_i,
  input  logic [DATA_WIDTH*NUM_BYPASS-1:0] byp_data_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [DATA_WIDTH-1:0]            result_o,
  output logic [DATA_WIDTH-1:0]            store_data_o
);

  localparam int SHW = $clog2(DATA_WIDTH);

  localparam logic [2:0] SP_NONE  = 3'd0;
  localparam logic [2:0] SP_JAL   = 3'd1;
  localparam logic [2:0] SP_JALR  = 3'd2;
  localparam logic [2:0] SP_AUIPC = 3'd3;
  localparam logic [2:0] SP_LUI   = 3'd4;
  localparam logic [2:0] SP_STORE = 3'd5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  // Lowest-index matching source wins, so scan from the top down; x0 never forwards.
  function automatic logic [DATA_WIDTH-1:0] resolve(input logic [4:0] idx,
                                                    input logic [DATA_WIDTH-1:0] regval);
    logic [DATA_WIDTH-1:0] r;
    r = regval;
    for (int k = NUM_BYPASS - 1; k >= 0; k--) begin
      if (byp_valid_i[k] && (byp_idx_i[5*k +: 5] == idx) && (idx != 5'd0)) begin
        r = byp_data_i[DATA_WIDTH*k +: DATA_WIDTH];
      end
    end
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] alu(input logic [DATA_WIDTH-1:0] a,
                                                input logic [DATA_WIDTH-1:0] b,
                                                input logic [3:0] op,
                                                input logic word);
    logic [DATA_WIDTH-1:0] r;
    logic [31:0]           a32;
    logic [31:0]           b32;
    logic signed [31:0]    w;
    a32 = a[31:0];
    b32 = b[31:0];
    if (word) begin
      case (op)
        OP_ADD:  w = a32 + b32;
        OP_SUB:  w = a32 - b32;
        OP_SLL:  w = a32 << b32[4:0];
        OP_SLT:  w = {31'd0, $signed(a32) < $signed(b32)};
        OP_SLTU: w = {31'd0, a32 < b32};
        OP_XOR:  w = a32 ^ b32;
        OP_SRL:  w = a32 >> b32[4:0];
        OP_SRA:  w = $signed(a32) >>> b32[4:0];
        OP_OR:   w = a32 | b32;
        OP_AND:  w = a32 & b32;
        default: w = 32'sd0;
      endcase
      r = DATA_WIDTH'(w);
    end else begin
      case (op)
        OP_ADD:  r = a + b;
        OP_SUB:  r = a - b;
        OP_SLL:  r = a << b[SHW-1:0];
        OP_SLT:  r = DATA_WIDTH'($signed(a) < $signed(b));
        OP_SLTU: r = DATA_WIDTH'(a < b);
        OP_XOR:  r = a ^ b;
        OP_SRL:  r = a >> b[SHW-1:0];
        OP_SRA:  r = $signed(a) >>> b[SHW-1:0];
        OP_OR:   r = a | b;
        OP_AND:  r = a & b;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  logic                  s1_valid_r, s2_valid_r;
  logic [DATA_WIDTH-1:0] s1_a_r, s1_b_r, s1_store_r;
  logic [3:0]            s1_op_r;
  logic                  s1_word_r;
  logic [DATA_WIDTH-1:0] s2_result_r, s2_store_r;

  logic                  s1_adv_s, s2_adv_s;
  logic [DATA_WIDTH-1:0] rs1_eff_s, rs2_eff_s, op_a_s, op_b_s, store_s;
  logic [3:0]            op_s;
  logic                  word_s;

  assign s2_adv_s   = !s2_valid_r || out_ready_i;
  assign s1_adv_s   = !s1_valid_r || s2_adv_s;
  assign in_ready_o = s1_adv_s && !flush_i;

  // Stage 1 operand selection with forwarding.
  always_comb begin
    rs1_eff_s = resolve(rs1_idx_i, rs1_i);
    rs2_eff_s = resolve(rs2_idx_i, rs2_i);
    case (specinst_i)
      SP_JAL, SP_JALR, SP_AUIPC: op_a_s = pc_i;
      default:                   op_a_s = ers1_i ? rs1_eff_s : '0;
    endcase
    case (specinst_i)
      SP_JAL, SP_JALR:           op_b_s = DATA_WIDTH'(4);
      SP_STORE, SP_LUI, SP_AUIPC: op_b_s = imme_i;
      default:                   op_b_s = ers2_i ? rs2_eff_s : imme_i;
    endcase
    if (specinst_i != SP_NONE) begin
      op_s = OP_ADD;
    end else begin
      op_s = alu_op_i;
    end
    if (specinst_i == SP_STORE) begin
      store_s = rs2_eff_s;
    end else begin
      store_s = '0;
    end
    word_s = word_op_i && (WORD_OPS != 0);
  end

  // Stage 1 register: captures selected operands on an accepted transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
      s1_store_r <= '0;
      s1_op_r    <= 4'd0;
      s1_word_r  <= 1'b0;
    end else if (flush_i) begin
      s1_valid_r <= 1'b0;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid_i;
      if (in_valid_i) begin
        s1_a_r     <= op_a_s;
        s1_b_r     <= op_b_s;
        s1_store_r <= store_s;
        s1_op_r    <= op_s;
        s1_word_r  <= word_s;
      end
    end
  end

  // Stage 2 register: holds the ALU result until downstream takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid_r  <= 1'b0;
      s2_result_r <= '0;
      s2_store_r  <= '0;
    end else if (flush_i) begin
      s2_valid_r <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_result_r <= alu(s1_a_r, s1_b_r, s1_op_r, s1_word_r);
        s2_store_r  <= s1_store_r;
      end
    end
  end

  assign out_valid_o  = s2_valid_r;
  assign result_o     = s2_result_r;
  assign store_data_o = s2_store_r;

endmodule

// File: tb/tb_exu_pipe.sv
// Directed bench for exu_pipe (64-bit, two bypass sources, W-ops enabled).
module tb_exu_pipe;

  logic         clk_i = 1'b0;
  logic         rst_ni, flush_i, in_valid_i, in_ready_o;
  logic         ers1_i, ers2_i, word_op_i, out_valid_o, out_ready_i;
  logic [2:0]   specinst_i;
  logic [3:0]   alu_op_i;
  logic [4:0]   rs1_idx_i, rs2_idx_i;
  logic [63:0]  rs1_i, rs2_i, pc_i, imme_i, result_o, store_data_o;
  logic [1:0]   byp_valid_i;
  logic [9:0]   byp_idx_i;
  logic [127:0] byp_data_i;

  int tests_run = 0;
  int tests_failed = 0;

  exu_pipe #(.DATA_WIDTH(64), .NUM_BYPASS(2), .WORD_OPS(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .ers1_i(ers1_i), .ers2_i(ers2_i), .specinst_i(specinst_i),
    .alu_op_i(alu_op_i), .word_op_i(word_op_i),
    .rs1_idx_i(rs1_idx_i), .rs2_idx_i(rs2_idx_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .pc_i(pc_i), .imme_i(imme_i),
    .byp_valid_i(byp_valid_i), .byp_idx_i(byp_idx_i), .byp_data_i(byp_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .store_data_o(store_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [2:0] sp, input logic [3:0] op, input logic wd,
                       input logic e1, input logic e2, input logic [4:0] i1, input logic [4:0] i2,
                       input logic [63:0] r1, input logic [63:0] r2,
                       input logic [63:0] pc, input logic [63:0] imm);
    in_valid_i = 1'b1;
    specinst_i = sp;  alu_op_i = op;  word_op_i = wd;
    ers1_i = e1;      ers2_i = e2;
    rs1_idx_i = i1;   rs2_idx_i = i2;
    rs1_i = r1;       rs2_i = r2;
    pc_i = pc;        imme_i = imm;
    byp_valid_i = 2'b00;
  endtask

  initial begin
    rst_ni = 1'b0;  flush_i = 1'b0;  out_ready_i = 1'b1;
    in_valid_i = 1'b0;
    drive(3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    in_valid_i = 1'b0;
    byp_idx_i = 10'd0;  byp_data_i = 128'd0;
    #2;
    check("reset_out_valid", {63'd0, out_valid_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_store", store_data_o, 64'd0);
    check("reset_in_ready", {63'd0, in_ready_o}, 64'd1);
    step();
    rst_ni = 1'b1;
    step();

    // Back-to-back stream: each result is checked two steps after it is driven.
    drive(3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 64'd5, 64'd7, 64'd0, 64'd0);
    step();
    check("add_lat_not_yet", {63'd0, out_valid_o}, 64'd0);
    drive(3'd1, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 64'd0, 64'd0, 64'h1000, 64'd0);
    step();
    check("add_valid", {63'd0, out_valid_o}, 64'd1);
    check("add_result", result_o, 64'd12);
    drive(3'd3, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 64'd0, 64'd0, 64'h1000, 64'h5000);
    step();
    check("jal", result_o, 64'h1004);
    check("stream_valid", {63'd0, out_valid_o}, 64'd1);
    drive(3'd4, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 64'd0, 64'd0, 64'h1000, 64'hABCD000);
    step();
    check("auipc", result_o, 64'h6000);
    drive(3'd0, 4'd0, 1'b0, 1'b1, 1'b0, 5'd3, 5'd0, 64'h77, 64'd0, 64'd0, 64'd0);
    byp_valid_i = 2'b11;  byp_idx_i = {5'd3, 5'd3};  byp_data_i = {64'h22, 64'h11};
    step();
    check("lui", result_o, 64'hABCD000);
    drive(3'd0, 4'd0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 64'h55, 64'd0, 64'd0, 64'd0);
    byp_valid_i = 2'b11;  byp_idx_i = {5'd0, 5'd0};  byp_data_i = {64'h88, 64'h99};
    step();
    check("byp_priority", result_o, 64'h11);
    drive(3'd0, 4'd0, 1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 64'h7FFFFFFF, 64'd1, 64'd0, 64'd0);
    step();
    check("byp_x0", result_o, 64'h55);
    drive(3'd0, 4'd7, 1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 64'h80000000, 64'd4, 64'd0, 64'd0);
    step();
    check("addw", result_o, 64'hFFFFFFFF80000000);
    drive(3'd0, 4'd2, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 64'd1, 64'd63, 64'd0, 64'd0);
    step();
    check("sraw", result_o, 64'hFFFFFFFFF8000000);
    drive(3'd0, 4'd3, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0, 64'd0);
    step();
    check("sll63", result_o, 64'h8000000000000000);
    drive(3'd0, 4'd12, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 64'd5, 64'd7, 64'd0, 64'd0);
    step();
    check("slt", result_o, 64'd1);
    drive(3'd5, 4'd1, 1'b0, 1'b1, 1'b1, 5'd8, 5'd9, 64'h100, 64'h1234, 64'd0, 64'd8);
    byp_valid_i = 2'b01;  byp_idx_i = {5'd0, 5'd9};  byp_data_i = {64'd0, 64'hDEAD};
    step();
    check("undef_op", result_o, 64'd0);
    check("nonstore_data", store_data_o, 64'd0);
    drive(3'd0, 4'd7, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 64'h8000000000000000, 64'd4, 64'd0, 64'd0);
    step();
    check("store_addr", result_o, 64'h108);
    check("store_data", store_data_o, 64'hDEAD);
    in_valid_i = 1'b0;
    step();
    check("sra64", result_o, 64'hF800000000000000);
    step();
    check("drain_idle", {63'd0, out_valid_o}, 64'd0);

    // Backpressure: two in flight while downstream stalls.
    out_ready_i = 1'b0;
    drive(3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 64'd1, 64'd1, 64'd0, 64'd0);
    step();
    drive(3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 64'd3, 64'd3, 64'd0, 64'd0);
    check("bp_ready_s1only", {63'd0, in_ready_o}, 64'd1);
    step();
    drive(3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 64'd10, 64'd10, 64'd0, 64'd0);
    check("bp_ready_low", {63'd0, in_ready_o}, 64'd0);
    check("bp_first", result_o, 64'd2);
    step();
    check("bp_hold1", result_o, 64'd2);
    check("bp_hold_valid", {63'd0, out_valid_o}, 64'd1);
    step();
    check("bp_hold2", result_o, 64'd2);
    out_ready_i = 1'b1;
    #1;
    check("bp_ready_release", {63'd0, in_ready_o}, 64'd1);
    step();
    in_valid_i = 1'b0;
    check("bp_second", result_o, 64'd6);
    step();
    check("bp_third", result_o, 64'd20);
    check("bp_third_valid", {63'd0, out_valid_o}, 64'd1);
    step();
    check("bp_empty", {63'd0, out_valid_o}, 64'd0);

    // Flush with two instructions in flight.
    drive(3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 64'd1, 64'd2, 64'd0, 64'd0);
    step();
    drive(3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 64'd2, 64'd2, 64'd0, 64'd0);
    step();
    check("pre_flush", result_o, 64'd3);
    flush_i = 1'b1;
    drive(3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 64'd9, 64'd9, 64'd0, 64'd0);
    #1;
    check("flush_ready", {63'd0, in_ready_o}, 64'd0);
    step();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    check("flush_valid", {63'd0, out_valid_o}, 64'd0);
    step();
    check("flush_no_accept", {63'd0, out_valid_o}, 64'd0);

    // Asynchronous reset mid-stream.
    drive(3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 64'd5, 64'd5, 64'd0, 64'd0);
    step();
    in_valid_i = 1'b0;
    step();
    check("pre_rst_valid", {63'd0, out_valid_o}, 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, out_valid_o}, 64'd0);
    check("async_rst_result", result_o, 64'd0);
    step();
    rst_ni = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
